riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between `riscv_core` and `data_mem`. It sequences every core memory access into a single-cycle request pulse and holds the core stalled until the memory responds. It converts byte/half/word accesses into word-aligned transfers with byte enables, and sign- or zero-extends read data. It replaces the ad-hoc stall flop in the top level and adds misalignment detection and a response watchdog.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `mem_ready_i` before aborting; 0 disables the watchdog.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `core_req_i` in 1: core requests a memory access; held stable while `core_stall_o` is high.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: access size, funct3 encoding: B=0, H=1, W=2, BU=4, HU=5.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, right-aligned.
- `core_rd_o` out 32: formatted load data; valid in the completion cycle.
- `core_stall_o` out 1: core must hold state.
- `misaligned_o` out 1: access rejected as misaligned (1-cycle pulse).
- `timeout_o` out 1: access aborted by the watchdog (1-cycle pulse).
- `mem_req_o` out 1: single-cycle request to memory.
- `mem_we_o` out 1: write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, `{core_addr_i[31:2],2'b00}`.
- `mem_wd_o` out 32: lane-replicated store data.
- `mem_rd_i` in 32: read word; valid when `mem_ready_i` is high.
- `mem_ready_i` in 1: response valid, for both loads and stores.

## Operation
- FSM states: IDLE and WAIT.
- IDLE, `core_req_i`=1, aligned access:
  - `mem_req_o`=1 and `core_stall_o`=1, both combinational.
  - Latch `core_size_i`, `core_addr_i[1:0]` and `core_we_i`.
  - Go to WAIT and clear the watchdog counter.
- IDLE, `core_req_i`=1, misaligned access (H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0):
  - `misaligned_o`=1, `mem_req_o`=0, `core_stall_o`=0, `core_rd_o`=0.
  - Stay in IDLE.
- IDLE, `core_req_i`=0: all strobes 0. Any `mem_ready_i` is ignored.
- WAIT, `mem_ready_i`=1:
  - `core_stall_o`=0.
  - `core_rd_o` = formatted `mem_rd_i` for loads, 0 for stores.
  - Go to IDLE.
- WAIT, `mem_ready_i`=0:
  - `core_stall_o`=1 and the counter increments.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: `timeout_o`=1, `core_stall_o`=0, `core_rd_o`=0, go to IDLE.
- WAIT, `mem_ready_i` and timeout in the same cycle: `mem_ready_i` wins and `timeout_o` stays 0.
- No re-request is issued in WAIT. `mem_req_o`=0 throughout WAIT.
- Byte enables (driven for loads too; memory ignores them on reads):
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `addr[1]` ? `4'b1100` : `4'b0011`.
  - W: `4'b1111`.
- Store data replication: B → `{4{wd[7:0]}}`; H → `{2{wd[15:0]}}`; W → `wd`.
- Load format uses the latched offset and size:
  - B/H: select the lane, then sign-extend.
  - BU/HU: select the lane, then zero-extend.
  - W: pass through.
- Watchdog counter width is `$clog2(TIMEOUT+1)`, with a minimum of 1. It saturates and never wraps.

## Timing
- Reset (asynchronous, `rst_i`=0): state IDLE, counter 0.
- All outputs are 0 during reset; the address and data outputs follow the combinational rules above.
- Reset asserted in WAIT aborts the access immediately and drops the stall. No response is delivered afterwards; a late `mem_ready_i` is ignored.
- A memory with fixed one-cycle response (synchronous `data_mem` with ready tied 1) gives:
  - cycle 0: request + stall;
  - cycle 1: unstall + data.
  - This is exactly one stall cycle per access.
- Back-to-back accesses: a new request is accepted in the IDLE cycle right after completion. Minimum 2 cycles per access.
- `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wd_o` are combinational from the core inputs. They are sampled by memory only in the `mem_req_o` cycle.

## Structure
- Shared `riscv_pkg` holds:
  - the size constants `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU`;
  - the `lsu_state_t` enum (IDLE, WAIT).
- Sub-module `lsu_rd_format`: purely combinational. Inputs are size, offset and the 32-bit word; output is the extended result.
- `riscv_lsu` holds the FSM, the watchdog counter, the byte-enable and replication logic, and the misalignment check.

## Test plan
- Store B to 0x1003 with wd=0x000000A5, ready tied 1 → cycle 0: req=1, be=4'b1000, wd=0xA5A5A5A5, addr=0x1000, stall=1; cycle 1: stall=0.
- Load B and BU from offset 2 with `mem_rd_i`=0x00F00000 → rd=0xFFFFFFF0 (B), 0x000000F0 (BU); one stall cycle each.
- Load H to 0x2001 → misaligned_o=1, req=0, stall=0, rd=0. Load W to 0x2002 → same response.
- Ready delayed 3 cycles, TIMEOUT=8 → stall high for 4 cycles, req high for 1 cycle only, data delivered in the ready cycle.
- Ready never asserted, TIMEOUT=4 → timeout_o pulse 4 cycles after entering WAIT, stall drops, rd=0. Ready arriving on the timeout cycle → normal completion with timeout_o=0.
- `rst_i` driven low in WAIT → stall and req drop to 0 asynchronously. After release, a late ready is ignored and the next request proceeds normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared size encodings, LSU state type and alignment helper
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // size[1:0] carries the width for both signed and unsigned encodings
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_rd_format.sv
// rtl/lsu_rd_format.sv - lane select and sign/zero extension of a loaded word
module lsu_rd_format
    import riscv_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (off_i)
            2'd0:    byte_lane = word_i[7:0];
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            default: byte_lane = word_i[31:24];
        endcase
        half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        case (size_i)
            LDST_B:  data_o = {{24{byte_lane[7]}}, byte_lane};
            LDST_BU: data_o = {24'h000000, byte_lane};
            LDST_H:  data_o = {{16{half_lane[15]}}, half_lane};
            LDST_HU: data_o = {16'h0000, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store sequencer with byte enables, misalign check and response watchdog
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    lsu_state_t    state_q, state_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          mis;
    logic          tmo_hit;
    logic [31:0]   rd_fmt;
    logic [3:0]    be;

    assign mis     = is_misaligned(core_size_i, core_addr_i[1:0]);
    // counter starts at 0 on the first WAIT cycle, so the TIMEOUT-th WAIT cycle aborts
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    lsu_rd_format u_rd_format (
        .size_i (size_q),
        .off_i  (off_q),
        .word_i (mem_rd_i),
        .data_o (rd_fmt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (core_req_i && !mis) begin
                    state_d = WAIT;
                    size_d  = core_size_i;
                    off_d   = core_addr_i[1:0];
                    we_d    = core_we_i;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_ready_i || tmo_hit) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        case (core_size_i[1:0])
            2'b00:   be = 4'b0001 << core_addr_i[1:0];
            2'b01:   be = core_addr_i[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        case (core_size_i[1:0])
            2'b00:   mem_wd_o = {4{core_wd_i[7:0]}};
            2'b01:   mem_wd_o = {2{core_wd_i[15:0]}};
            default: mem_wd_o = core_wd_i;
        endcase
    end

    assign mem_addr_o = {core_addr_i[31:2], 2'b00};

    always_comb begin
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        misaligned_o = 1'b0;
        timeout_o    = 1'b0;
        core_rd_o    = 32'h0;
        mem_we_o     = core_we_i;
        mem_be_o     = be;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (mis) begin
                        misaligned_o = 1'b1;
                    end else begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ready_i) begin
                    core_rd_o = we_q ? 32'h0 : rd_fmt;
                end else if (tmo_hit) begin
                    timeout_o = 1'b1;
                end else begin
                    core_stall_o = 1'b1;
                end
            end
            default: ;
        endcase
        // reset must silence strobes immediately, even while the core still requests
        if (!rst_i) begin
            mem_req_o    = 1'b0;
            core_stall_o = 1'b0;
            misaligned_o = 1'b0;
            timeout_o    = 1'b0;
            core_rd_o    = 32'h0;
            mem_we_o     = 1'b0;
            mem_be_o     = 4'b0000;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed-vector bench for riscv_lsu
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req8, req4, ready8, ready4;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr, wd, mem_rd;

    logic [31:0] rd8, rd4, maddr8, maddr4, mwd8, mwd4;
    logic        stall8, stall4, mis8, mis4, tmo8, tmo4, mreq8, mreq4, mwe8, mwe4;
    logic [3:0]  be8, be4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_i), .core_req_i(req8), .core_we_i(we),
        .core_size_i(size), .core_addr_i(addr), .core_wd_i(wd),
        .core_rd_o(rd8), .core_stall_o(stall8), .misaligned_o(mis8), .timeout_o(tmo8),
        .mem_req_o(mreq8), .mem_we_o(mwe8), .mem_be_o(be8), .mem_addr_o(maddr8),
        .mem_wd_o(mwd8), .mem_rd_i(mem_rd), .mem_ready_i(ready8)
    );

    riscv_lsu #(.TIMEOUT(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .core_req_i(req4), .core_we_i(we),
        .core_size_i(size), .core_addr_i(addr), .core_wd_i(wd),
        .core_rd_o(rd4), .core_stall_o(stall4), .misaligned_o(mis4), .timeout_o(tmo4),
        .mem_req_o(mreq4), .mem_we_o(mwe4), .mem_be_o(be4), .mem_addr_o(maddr4),
        .mem_wd_o(mwd4), .mem_rd_i(mem_rd), .mem_ready_i(ready4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one access on the TIMEOUT=8 unit with ready tied high; leaves req asserted
    task automatic access8(input string tag, input logic w, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] mrd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
        req8 = 1'b1; we = w; size = s; addr = a; wd = d; mem_rd = mrd; ready8 = 1'b1;
        @(negedge clk);
        chk({tag, ".req"},   {31'b0, mreq8},  32'd1);
        chk({tag, ".stall"}, {31'b0, stall8}, 32'd1);
        chk({tag, ".be"},    {28'b0, be8},    {28'b0, exp_be});
        chk({tag, ".wd"},    mwd8,            exp_wd);
        chk({tag, ".addr"},  maddr8,          {a[31:2], 2'b00});
        next_cycle();
        @(negedge clk);
        chk({tag, ".unstall"}, {31'b0, stall8}, 32'd0);
        chk({tag, ".noreq"},   {31'b0, mreq8},  32'd0);
        chk({tag, ".rd"},      rd8,             exp_rd);
        next_cycle();
    endtask

    initial begin
        int stall_cnt;
        int req_cnt;

        rst_i = 1'b0; req8 = 1'b1; req4 = 1'b0; ready8 = 1'b0; ready4 = 1'b0;
        we = 1'b0; size = 3'd2; addr = 32'h0; wd = 32'h0; mem_rd = 32'h0;
        #12;
        chk("rst.req",   {31'b0, mreq8},  32'd0);
        chk("rst.stall", {31'b0, stall8}, 32'd0);
        chk("rst.rd",    rd8,             32'd0);
        next_cycle();
        rst_i = 1'b1; req8 = 1'b0;
        next_cycle();

        access8("stB",  1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access8("ldB",  1'b0, 3'd0, 32'h0000_3002, 32'h0, 32'h00F0_0000, 4'b0100, 32'h0, 32'hFFFF_FFF0);
        access8("ldBU", 1'b0, 3'd4, 32'h0000_3002, 32'h0, 32'h00F0_0000, 4'b0100, 32'h0, 32'h0000_00F0);
        access8("ldH",  1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
        access8("ldHU", 1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0, 32'h0000_8001);
        access8("stH",  1'b1, 3'd1, 32'h0000_2000, 32'h1234_ABCD, 32'h0, 4'b0011, 32'hABCD_ABCD, 32'h0);
        access8("ldW",  1'b0, 3'd2, 32'h0000_2004, 32'h1234_5678, 32'h8765_4321, 4'b1111, 32'h1234_5678, 32'h8765_4321);
        req8 = 1'b0;

        next_cycle();
        req8 = 1'b1; we = 1'b0; size = 3'd1; addr = 32'h0000_2001; mem_rd = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("misH.mis",   {31'b0, mis8},   32'd1);
        chk("misH.req",   {31'b0, mreq8},  32'd0);
        chk("misH.stall", {31'b0, stall8}, 32'd0);
        chk("misH.rd",    rd8,             32'd0);
        next_cycle();
        size = 3'd2; addr = 32'h0000_2002;
        @(negedge clk);
        chk("misW.mis",   {31'b0, mis8},   32'd1);
        chk("misW.req",   {31'b0, mreq8},  32'd0);
        chk("misW.stall", {31'b0, stall8}, 32'd0);
        next_cycle();
        req8 = 1'b0;
        next_cycle();

        // ready arrives after three WAIT cycles on the TIMEOUT=8 unit
        req8 = 1'b1; size = 3'd2; addr = 32'h0000_0040; mem_rd = 32'hCAFE_F00D; ready8 = 1'b0;
        stall_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ready8 = 1'b1;
            @(negedge clk);
            stall_cnt += int'(stall8);
            req_cnt   += int'(mreq8);
            if (i == 4) begin
                chk("dly.rd",  rd8,            32'hCAFE_F00D);
                chk("dly.tmo", {31'b0, tmo8},  32'd0);
            end
            next_cycle();
        end
        req8 = 1'b0;
        chk("dly.stall_cycles", stall_cnt, 32'd4);
        chk("dly.req_cycles",   req_cnt,   32'd1);
        next_cycle();

        // TIMEOUT=4 unit: memory never answers
        req4 = 1'b1; size = 3'd2; addr = 32'h0000_0080; ready4 = 1'b0; mem_rd = 32'h5555_5555;
        stall_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) req4 = 1'b0;
            @(negedge clk);
            stall_cnt += int'(stall4);
            req_cnt   += int'(tmo4);
            if (i == 4) begin
                chk("tmo.pulse", {31'b0, tmo4},   32'd1);
                chk("tmo.stall", {31'b0, stall4}, 32'd0);
                chk("tmo.rd",    rd4,             32'd0);
            end
            next_cycle();
        end
        chk("tmo.stall_cycles", stall_cnt, 32'd4);
        chk("tmo.pulses",       req_cnt,   32'd1);

        // ready on the would-be timeout cycle wins
        req4 = 1'b1; addr = 32'h0000_0084; mem_rd = 32'h1122_3344;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ready4 = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                chk("race.tmo",   {31'b0, tmo4},   32'd0);
                chk("race.stall", {31'b0, stall4}, 32'd0);
                chk("race.rd",    rd4,             32'h1122_3344);
            end
            next_cycle();
        end
        req4 = 1'b0; ready4 = 1'b0;
        next_cycle();

        // reset asserted while waiting
        req8 = 1'b1; size = 3'd2; addr = 32'h0000_0100; ready8 = 1'b0;
        @(negedge clk);
        chk("rstw.stall0", {31'b0, stall8}, 32'd1);
        @(posedge clk);
        #2;
        chk("rstw.wait_stall", {31'b0, stall8}, 32'd1);
        chk("rstw.wait_req",   {31'b0, mreq8},  32'd0);
        rst_i = 1'b0;
        #1;
        chk("rstw.stall", {31'b0, stall8}, 32'd0);
        chk("rstw.req",   {31'b0, mreq8},  32'd0);
        next_cycle();
        rst_i = 1'b1; req8 = 1'b0; ready8 = 1'b1; mem_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("late.stall", {31'b0, stall8}, 32'd0);
        chk("late.rd",    rd8,             32'd0);
        chk("late.req",   {31'b0, mreq8},  32'd0);
        next_cycle();
        access8("post", 1'b0, 3'd0, 32'h0000_0105, 32'h0, 32'h0000_7F00, 4'b0010, 32'h0, 32'h0000_007F);
        req8 = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
